// File: rtl/msg_check_pkg.sv
// Shared types and ASCII constants for the decrypted-message checkers.
package msg_check_pkg;

    typedef enum logic {
        MODE_LOWER_SPACE = 1'b0,
        MODE_PRINTABLE   = 1'b1
    } check_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_SPACE     = 8'd32;
    localparam logic [7:0] ASCII_A_LO      = 8'd97;
    localparam logic [7:0] ASCII_Z_LO      = 8'd122;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'd32;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'd126;

endpackage

// File: rtl/msg_stream_checker_classifier.sv
// Combinational character-class test for one message byte.
module ascii_char_classifier
    import msg_check_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       mode_i,
    output logic       ok_o
);

    logic is_lower;
    logic is_space;
    logic is_print;

    always_comb begin
        is_lower = (data_i >= ASCII_A_LO) && (data_i <= ASCII_Z_LO);
        is_space = (data_i == ASCII_SPACE);
        is_print = (data_i >= ASCII_PRINT_MIN) && (data_i <= ASCII_PRINT_MAX);
        if (check_mode_t'(mode_i) == MODE_PRINTABLE) begin
            ok_o = is_print;
        end else begin
            ok_o = is_lower | is_space;
        end
    end

endmodule

// File: rtl/msg_stream_checker.sv
// Walks the decrypted-message RAM and checks each byte against a character
// class, aborting on the first bad byte.
module msg_stream_checker
    import msg_check_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              restart,
    input  logic              mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              finish,
    output logic              key_is_wrong,
    output logic [ADDR_W-1:0] bad_index,
    output logic [ADDR_W:0]   pass_count
);

    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              kiw_q, kiw_d;
    logic [ADDR_W-1:0] bad_q, bad_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic              byte_ok;

    ascii_char_classifier u_cls (
        .data_i (rd_data),
        .mode_i (mode_q),
        .ok_o   (byte_ok)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        kiw_d   = kiw_q;
        bad_d   = bad_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    kiw_d   = 1'b0;
                    bad_d   = '0;
                    pc_d    = '0;
                    index_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (RD_LAT > 1) begin
                    cnt_d   = CNT_W'(RD_LAT - 2);
                    state_d = WAIT;
                end else begin
                    state_d = CHECK;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (!byte_ok) begin
                    kiw_d   = 1'b1;
                    bad_d   = index_q;
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
                    if (index_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // restart overrides everything, including a same-cycle start
        if (restart) begin
            state_d = IDLE;
            index_d = '0;
            cnt_d   = '0;
            kiw_d   = 1'b0;
            bad_d   = '0;
            pc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            index_q <= '0;
            cnt_q   <= '0;
            kiw_q   <= 1'b0;
            bad_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            kiw_q   <= kiw_d;
            bad_q   <= bad_d;
            pc_q    <= pc_d;
        end
    end

    assign rd_en        = (state_q == READ);
    assign rd_addr      = index_q;
    assign busy         = (state_q != IDLE);
    assign finish       = (state_q == DONE);
    assign key_is_wrong = kiw_q;
    assign bad_index    = bad_q;
    assign pass_count   = pc_q;

endmodule

// File: tb/tb_msg_stream_checker.sv
// Scoreboard bench: two checker instances (default and RD_LAT=3/MSG_LEN=4)
// against behavioural RAMs with matching read latency.
module tb_msg_stream_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       a_start = 1'b0, a_restart = 1'b0, a_mode = 1'b0;
    logic       a_rd_en, a_busy, a_fin, a_kiw;
    logic [4:0] a_addr, a_bad;
    logic [5:0] a_pc;
    logic [7:0] a_rdata;

    logic       b_start = 1'b0, b_restart = 1'b0, b_mode = 1'b0;
    logic       b_rd_en, b_busy, b_fin, b_kiw;
    logic [1:0] b_addr, b_bad;
    logic [2:0] b_pc;
    logic [7:0] b_rdata;

    msg_stream_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .restart(a_restart),
        .mode(a_mode), .rd_en(a_rd_en), .rd_addr(a_addr), .rd_data(a_rdata),
        .busy(a_busy), .finish(a_fin), .key_is_wrong(a_kiw),
        .bad_index(a_bad), .pass_count(a_pc)
    );

    msg_stream_checker #(.MSG_LEN(4), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .restart(b_restart),
        .mode(b_mode), .rd_en(b_rd_en), .rd_addr(b_addr), .rd_data(b_rdata),
        .busy(b_busy), .finish(b_fin), .key_is_wrong(b_kiw),
        .bad_index(b_bad), .pass_count(b_pc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [4];
    logic [7:0] a_pipe;
    logic [7:0] b_pipe [3];

    always @(posedge clk) begin
        a_pipe    <= mem_a[a_addr];
        b_pipe[0] <= mem_b[b_addr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_rdata = a_pipe;
    assign b_rdata = b_pipe[2];

    typedef struct {
        int fin;
        int kiw;
        int bad;
        int pc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int total = 0;
    int bad = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    int a_rd_cnt = 0, a_rd_max = 0, a_seq_err = 0;
    int b_rd_cyc[$];

    always @(negedge clk) begin
        exp_t e;
        if (a_rd_en) begin
            if (int'(a_addr) != a_rd_cnt) a_seq_err++;
            if (int'(a_addr) > a_rd_max) a_rd_max = int'(a_addr);
            a_rd_cnt++;
        end
        if (b_rd_en) b_rd_cyc.push_back(cyc);
        if (a_fin) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_finish", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_finish_cyc", cyc, e.fin);
                chk("a_key_is_wrong", int'(a_kiw), e.kiw);
                chk("a_bad_index", int'(a_bad), e.bad);
                chk("a_pass_count", int'(a_pc), e.pc);
            end
        end
        if (b_fin) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_finish", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_finish_cyc", cyc, e.fin);
                chk("b_key_is_wrong", int'(b_kiw), e.kiw);
                chk("b_bad_index", int'(b_bad), e.bad);
                chk("b_pass_count", int'(b_pc), e.pc);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_a(logic m, output int t);
        a_mode  = m;
        a_start = 1'b1;
        t = cyc;
        tick();
        a_start = 1'b0;
    endtask

    task automatic start_b(logic m, output int t);
        b_mode  = m;
        b_start = 1'b1;
        t = cyc;
        tick();
        b_start = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while (qa.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (qa.size() != 0) begin
            chk("a_timeout", qa.size(), 0);
            qa.delete();
        end
        tick(2);
    endtask

    task automatic wait_b();
        int n = 0;
        while (qb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (qb.size() != 0) begin
            chk("b_timeout", qb.size(), 0);
            qb.delete();
        end
        tick(2);
    endtask

    task automatic chk_a_reset(string tag);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_finish"}, int'(a_fin), 0);
        chk({tag, "_kiw"}, int'(a_kiw), 0);
        chk({tag, "_bad"}, int'(a_bad), 0);
        chk({tag, "_pc"}, int'(a_pc), 0);
        chk({tag, "_rd_en"}, int'(a_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(a_addr), 0);
    endtask

    task automatic clr_a_rd();
        a_rd_cnt  = 0;
        a_rd_max  = 0;
        a_seq_err = 0;
    endtask

    logic [7:0] bv [13] = '{8'd32, 8'd97, 8'd122, 8'd31, 8'd96, 8'd123, 8'd65,
                            8'd126, 8'd72, 8'd0, 8'd127, 8'd128, 8'd255};
    bit bm [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit bf [13] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};

    initial begin
        int t;
        int seen;
        string hw;
        hw = "hello world";
        for (int i = 0; i < 32; i++) mem_a[i] = 8'd97;
        for (int i = 0; i < 11; i++) mem_a[i] = hw[i];
        for (int i = 0; i < 4; i++) mem_b[i] = 8'd122;

        tick(3);
        chk_a_reset("rst");
        chk("rst_b_busy", int'(b_busy), 0);
        rst_n = 1'b1;
        tick(2);

        // full pass, mode 0, with a start pulse mid-run that must be ignored
        clr_a_rd();
        start_a(1'b0, t);
        qa.push_back('{t + 65, 0, 0, 32});
        tick(8);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_a();
        chk("a_rd_count_full", a_rd_cnt, 32);
        chk("a_rd_seq", a_seq_err, 0);

        // early abort on 'H' at index 5
        mem_a[5] = 8'd72;
        clr_a_rd();
        start_a(1'b0, t);
        qa.push_back('{t + 13, 1, 5, 5});
        wait_a();
        chk("a_rd_count_abort", a_rd_cnt, 6);
        chk("a_rd_max_abort", a_rd_max, 5);

        // printable mode; mode flip after start must not matter
        start_a(1'b1, t);
        a_mode = 1'b0;
        qa.push_back('{t + 65, 0, 0, 32});
        wait_a();
        mem_a[10] = 8'd127;
        start_a(1'b1, t);
        qa.push_back('{t + 23, 1, 10, 10});
        wait_a();
        chk("a_hold_kiw", int'(a_kiw), 1);
        chk("a_hold_bad", int'(a_bad), 10);

        // restart mid-run at t+7
        mem_a[5]  = 8'd97;
        mem_a[10] = 8'd97;
        start_a(1'b0, t);
        tick(6);
        chk("a_pc_before_restart", int'(a_pc), 3);
        a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        chk("rs_busy", int'(a_busy), 0);
        chk("rs_kiw", int'(a_kiw), 0);
        chk("rs_pc", int'(a_pc), 0);
        tick(80);
        start_a(1'b0, t);
        qa.push_back('{t + 65, 0, 0, 32});
        wait_a();

        // synchronous reset while CHECK of a bad byte is pending
        mem_a[5] = 8'd72;
        start_a(1'b0, t);
        tick(11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_a_reset("midrst");
        seen = 0;
        repeat (30) begin
            tick();
            if (a_kiw) seen = 1;
        end
        chk("midrst_kiw_never", seen, 0);

        // start with restart in IDLE stays idle
        a_start   = 1'b1;
        a_restart = 1'b1;
        tick();
        a_start   = 1'b0;
        a_restart = 1'b0;
        chk("sr_busy", int'(a_busy), 0);
        tick(3);
        chk("sr_busy_later", int'(a_busy), 0);

        // RD_LAT=3, MSG_LEN=4 timing
        b_rd_cyc.delete();
        start_b(1'b0, t);
        qb.push_back('{t + 17, 0, 0, 4});
        wait_b();
        chk("b_rd_count", b_rd_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < b_rd_cyc.size())
                chk($sformatf("b_rd_cyc%0d", k), b_rd_cyc[k], t + 1 + 4 * k);
        end

        // class boundaries at index 0
        for (int k = 0; k < 13; k++) begin
            mem_b[0] = bv[k];
            start_b(bm[k], t);
            if (bf[k]) qb.push_back('{t + 5, 1, 0, 0});
            else       qb.push_back('{t + 17, 0, 0, 4});
            wait_b();
        end

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_stream_checker.md
Name: msg_stream_checker

Overview:
Parametrised successor to the single-byte decrypted-message checker. On start, it walks a decrypted-message RAM of MSG_LEN bytes through a read port with fixed latency, and checks every byte against a selectable character class. It reports pass/fail for the candidate key, the index of the first offending byte, and the number of bytes that passed. It sits between the RC4 decrypt core's output RAM and the key-search controller, which issues start/restart per candidate key.

Parameters:
MSG_LEN, 32, number of message bytes checked per run (>=1)
ADDR_W, $clog2(MSG_LEN) (min 1), width of rd_addr and bad_index
RD_LAT, 1, cycles from rd_en to valid rd_data (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; synchronous, active-low
start  in  1  begin a check run; sampled only in IDLE
restart  in  1  abort any run, return to IDLE, clear results
mode  in  1  0: lowercase a-z (97..122) or space (32); 1: printable ASCII 32..126; latched at start
rd_en  out  1  read strobe to message RAM
rd_addr  out  ADDR_W  byte index being read
rd_data  in  8  RAM data, valid RD_LAT cycles after rd_en
busy  out  1  high from the cycle after start is accepted until finish
finish  out  1  one-cycle pulse at end of run (pass or fail)
key_is_wrong  out  1  sticky; set on first bad byte, held until restart/start/reset
bad_index  out  ADDR_W  index of first bad byte; valid while key_is_wrong=1, else 0
pass_count  out  ADDR_W+1  bytes checked and passed in current/last run

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; rd_en=0, rd_addr=0, busy=0, finish=0, key_is_wrong=0, bad_index=0, pass_count=0.
- States: IDLE, READ, WAIT, CHECK, DONE.
- IDLE: on start=1 (restart=0), latch mode, clear key_is_wrong/bad_index/pass_count, set index=0, go to READ.
- READ: one cycle. rd_en=1, rd_addr=index. Go to WAIT if RD_LAT>1, else to CHECK.
- WAIT: hold for RD_LAT-1 cycles using a down-counter, then go to CHECK.
- CHECK: rd_data is sampled on the cycle exactly RD_LAT after rd_en.
  - Byte fails: key_is_wrong<=1, bad_index<=index, go to DONE (early abort).
  - Byte passes and index==MSG_LEN-1: pass_count++, go to DONE.
  - Byte passes otherwise: pass_count++, index++, go to READ.
- Each byte costs RD_LAT+1 cycles.
- DONE: finish=1 for exactly one cycle, then go to IDLE. Results hold until the next start, restart or reset.
- Timing: start accepted at cycle t. Byte i is read at t+1+i*(RD_LAT+1) and checked RD_LAT cycles later. An all-pass run pulses finish at t+1+MSG_LEN*(RD_LAT+1). Defaults: t+65.
- busy=1 in READ/WAIT/CHECK/DONE.
- start while busy: ignored, no effect.
- restart=1 in any state: next state IDLE, and all outputs return to reset values. No finish pulse. restart wins over a simultaneous start.
- rst_n=0 mid-run: identical to reset; any in-flight read data is discarded.
- Boundaries:
  - pass_count reaches MSG_LEN on a full pass; its width holds MSG_LEN without wrap.
  - index never exceeds MSG_LEN-1.
  - Values 0, 31, 127 and 128..255 fail in both modes.
  - In mode 0, 33..96 and 123..126 fail.
- mode changes after start have no effect on the current run.

Decomposition:
- Package msg_check_pkg:
  - enum check_mode_t {MODE_LOWER_SPACE, MODE_PRINTABLE}
  - enum state_t {IDLE, READ, WAIT, CHECK, DONE}
  - constants ASCII_SPACE=32, ASCII_A_LO=97, ASCII_Z_LO=122, ASCII_PRINT_MIN=32, ASCII_PRINT_MAX=126
- Sub-module ascii_char_classifier: purely combinational (data[7:0], mode) -> ok. Instantiated once, reused by the top-level FSM and by future checkers.

Test Plan:
- Defaults, mode=0, RAM holds "hello world" padded with 'a' to 32 bytes; start -> finish pulse at t+65, key_is_wrong=0, pass_count=32, exactly 32 rd_en pulses on addresses 0..31.
- mode=0, byte 5 = 'H' (72) -> finish at t+1+6*2=t+13, key_is_wrong=1, bad_index=5, pass_count=5, no rd_en after address 5.
- mode=1, same RAM -> 'H' passes, full pass with pass_count=32. Then byte 10 = 127 -> key_is_wrong=1, bad_index=10.
- RD_LAT=3, MSG_LEN=4, all 'z' -> rd_en at t+1, t+5, t+9, t+13; finish at t+17. Boundary bytes 32, 97 and 122 pass; 31, 96 and 123 fail when placed at index 0.
- restart asserted at cycle t+7 mid-run -> next cycle busy=0, key_is_wrong=0, pass_count=0, no finish. A subsequent start runs normally. A start pulsed while busy leaves the run timing unchanged.
- rst_n=0 for one cycle during CHECK with a bad byte pending -> all outputs go to reset values and key_is_wrong never rises. start together with restart in IDLE -> stays IDLE.
